// File: rtl/apb_resp_pkg.sv
// Shared types and sizing for the APB slave responder and its protocol checker.
// The optional checker is enabled by defining APB_RESP_CHECK_EN.
package apb_resp_pkg;

  localparam int NUM_REGIONS  = 4;
  localparam int REGION_WORDS = 16;
  localparam int DATA_W       = 32;
  localparam int ERR_CNT_W    = 8;
  localparam int REGION_BITS  = $clog2(NUM_REGIONS);
  localparam int WORD_BITS    = $clog2(REGION_WORDS);
  localparam int MEM_WORDS    = NUM_REGIONS * REGION_WORDS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Encodes a one-hot select into a region number; callers only use it on single-hot input.
  function automatic logic [REGION_BITS-1:0] sel_to_region(input logic [NUM_REGIONS-1:0] sel);
    logic [REGION_BITS-1:0] region;
    region = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel[i]) region = REGION_BITS'(i);
    end
    return region;
  endfunction

endpackage

// File: rtl/apb_resp_checker.sv
// APB protocol-violation detector with sticky flag and saturating counter.
// Only instantiated when APB_RESP_CHECK_EN is defined.
module apb_resp_checker
  import apb_resp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  state_t                 state,
  input  logic [NUM_REGIONS-1:0] sel,
  input  logic                   enable,
  input  logic                   write,
  input  logic [WORD_BITS-1:0]   addr,
  input  logic [NUM_REGIONS-1:0] cap_sel,
  input  logic [WORD_BITS-1:0]   cap_addr,
  input  logic                   cap_write,
  output logic                   violation,
  output logic                   prot_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  logic single_hot;
  logic multi_hot;
  logic new_setup;
  logic ctrl_change;

  assign single_hot  = $onehot(sel);
  assign multi_hot   = (sel != '0) && !single_hot;
  assign new_setup   = single_hot && !enable;
  assign ctrl_change = (sel != cap_sel) || (addr != cap_addr) || (write != cap_write);

  // Several rules can fire together; they still count as one violation per cycle.
  assign violation = (enable && (state == IDLE))
                  || (enable && (state == ACCESS))
                  || ((state == SETUP) && !enable && (sel != '0) && !new_setup)
                  || ((state == SETUP) && enable && ctrl_change)
                  || multi_hot;

  always_ff @(posedge clk) begin
    if (rst) begin
      prot_err <= 1'b0;
      err_cnt  <= '0;
    end else if (violation) begin
      prot_err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_slave_responder.sv
// APB slave responder: 4 regions x 16 words of storage behind a one-hot Psel.
// Define APB_RESP_CHECK_EN to build in protocol-violation checking.
module apb_slave_responder
  import apb_resp_pkg::*;
(
  input  logic                   clk,
  input  logic                   Prst,
  input  logic [NUM_REGIONS-1:0] Psel,
  input  logic                   Penable,
  input  logic                   Pwrite,
  input  logic [31:0]            Paddr,
  input  logic [DATA_W-1:0]      Pwdata,
  output logic [DATA_W-1:0]      Prdata,
  output logic                   prot_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  state_t state, next_state;

  logic [NUM_REGIONS-1:0]           cap_sel;
  logic [WORD_BITS-1:0]             cap_addr;
  logic                             cap_write;
  logic [WORD_BITS-1:0]             word_addr;
  logic [REGION_BITS+WORD_BITS-1:0] index;
  logic                             single_hot;
  logic                             multi_hot;
  logic                             setup_cycle;
  logic                             read_setup;
  logic                             advance;
  logic                             violation;
  logic                             write_en;
  logic                             unused_bits;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  assign word_addr   = Paddr[5:2];
  assign index       = {sel_to_region(Psel), word_addr};
  assign single_hot  = $onehot(Psel);
  assign multi_hot   = (Psel != '0) && !single_hot;
  assign setup_cycle = single_hot && !Penable;
  assign read_setup  = setup_cycle && !Pwrite;

`ifdef APB_RESP_CHECK_EN
  logic access_match;

  assign access_match = (state == SETUP) && Penable && (Psel == cap_sel)
                     && (word_addr == cap_addr) && (Pwrite == cap_write);
  assign advance      = access_match;
  assign write_en     = access_match && Pwrite && !violation;
  assign unused_bits  = ^{Paddr[31:6], Paddr[1:0]};

  apb_resp_checker u_checker (
    .clk       (clk),
    .rst       (Prst),
    .state     (state),
    .sel       (Psel),
    .enable    (Penable),
    .write     (Pwrite),
    .addr      (word_addr),
    .cap_sel   (cap_sel),
    .cap_addr  (cap_addr),
    .cap_write (cap_write),
    .violation (violation),
    .prot_err  (prot_err),
    .err_cnt   (err_cnt)
  );
`else
  // Without the checker the access phase trusts the bus and uses the live address.
  assign advance     = (state == SETUP) && Penable && single_hot;
  assign write_en    = advance && Pwrite;
  assign violation   = 1'b0;
  assign prot_err    = 1'b0;
  assign err_cnt     = '0;
  assign unused_bits = ^{Paddr[31:6], Paddr[1:0], cap_sel, cap_addr, cap_write};
`endif

  always_comb begin
    next_state = IDLE;
    if (violation || multi_hot) begin
      next_state = IDLE;
    end else if (setup_cycle) begin
      next_state = SETUP;
    end else if (advance) begin
      next_state = ACCESS;
    end
  end

  // Prdata only holds a word for the access cycle that follows a read setup.
  always_ff @(posedge clk) begin
    if (Prst) begin
      state     <= IDLE;
      cap_sel   <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      Prdata    <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= next_state;
      if (setup_cycle) begin
        cap_sel   <= Psel;
        cap_addr  <= word_addr;
        cap_write <= Pwrite;
      end
      if (write_en) mem[index] <= Pwdata;
      Prdata <= read_setup ? mem[index] : '0;
    end
  end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed table-driven bench for apb_slave_responder, valid with or without APB_RESP_CHECK_EN.
module tb_apb_slave_responder;
  import apb_resp_pkg::*;

`ifdef APB_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   Prst;
  logic [NUM_REGIONS-1:0] Psel;
  logic                   Penable;
  logic                   Pwrite;
  logic [31:0]            Paddr;
  logic [DATA_W-1:0]      Pwdata;
  logic [DATA_W-1:0]      Prdata;
  logic                   prot_err;
  logic [ERR_CNT_W-1:0]   err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  apb_slave_responder dut (
    .clk      (clk),
    .Prst     (Prst),
    .Psel     (Psel),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .prot_err (prot_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [3:0] sel, input logic en,
                              input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input logic err, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.sel = sel; v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.exp_cnt = cnt;
    return v;
  endfunction

  // Drives one bus cycle and returns 1 time unit after the edge that closes it.
  task automatic apply_stimulus(input logic rst, input logic [3:0] sel, input logic en,
                                input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    Prst = rst; Psel = sel; Penable = en; Pwrite = wr; Paddr = addr; Pwdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Error outputs are only live in checker builds; otherwise they must stay 0.
  task automatic check_all(input string name, input logic [31:0] rd, input logic err, input logic [7:0] cnt);
    check_output({name, ".Prdata"}, Prdata, rd);
    check_output({name, ".prot_err"}, {31'b0, prot_err}, {31'b0, err & CHK});
    check_output({name, ".err_cnt"}, {24'b0, err_cnt}, CHK ? {24'b0, cnt} : 32'h0);
  endtask

  initial begin
    Prst = 1'b1; Psel = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;

    // reset and write/read of region 1 word 2
    vecs.push_back(mk(1, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 32'h08, 32'hDEADBEEF, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 1, 32'h08, 32'hDEADBEEF, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 32'h08, 32'h0, 32'h0, 0, 0));
    // back-to-back writes to region 0 word 0 and region 3 word 15
    vecs.push_back(mk(0, 4'b0001, 0, 1, 32'h00, 32'h11, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 1, 32'h00, 32'h11, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 1, 32'h3C, 32'h22, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 1, 1, 32'h3C, 32'h22, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 32'h00, 32'h0, 32'h11, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 0, 32'h00, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 32'h3C, 32'h0, 32'h22, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 1, 0, 32'h3C, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 32'h3C, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 0, 32'h3C, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 0, 0));
    // upper and low address bits are ignored: 0xABCD000B decodes to word 2
    vecs.push_back(mk(0, 4'b0010, 0, 0, 32'hABCD000B, 32'h0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 32'hABCD000B, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 0, 0));
    // Penable without setup: no write to region 0 word 1
    vecs.push_back(mk(0, 4'b0001, 1, 1, 32'h04, 32'h99, 32'h0, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 1, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 32'h04, 32'h0, 32'h0, 1, 1));
    vecs.push_back(mk(0, 4'b0001, 1, 0, 32'h04, 32'h0, 32'h0, 1, 1));
    // multi-hot write attempt, then both candidate words read back as 0
    vecs.push_back(mk(0, 4'b0011, 0, 1, 32'h04, 32'h55, 32'h0, 1, 2));
    vecs.push_back(mk(0, 4'b0011, 1, 1, 32'h04, 32'h55, 32'h0, 1, 3));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 32'h04, 32'h0, 32'h0, 1, 3));
    vecs.push_back(mk(0, 4'b0001, 1, 0, 32'h04, 32'h0, 32'h0, 1, 3));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 32'h04, 32'h0, 32'h0, 1, 3));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 32'h04, 32'h0, 32'h0, 1, 3));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 32'h08, 32'h0, 32'h0, 1, 4));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 1, 4));
    // Penable held into a second access cycle: that second write is dropped
    vecs.push_back(mk(0, 4'b0100, 0, 1, 32'h20, 32'h33, 32'h0, 1, 4));
    vecs.push_back(mk(0, 4'b0100, 1, 1, 32'h20, 32'h33, 32'h0, 1, 4));
    vecs.push_back(mk(0, 4'b0100, 1, 1, 32'h20, 32'h44, 32'h0, 1, 5));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 1, 5));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 32'h20, 32'h0, 32'h33, 1, 5));
    vecs.push_back(mk(0, 4'b0100, 1, 0, 32'h20, 32'h0, 32'h0, 1, 5));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h00, 32'h0, 32'h0, 1, 5));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].sel, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check_all($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // Address changes between setup and access: the checker drops the write.
    apply_stimulus(0, 4'b0100, 0, 1, 32'h10, 32'hAA);
    apply_stimulus(0, 4'b0100, 1, 1, 32'h14, 32'hAA);
    check_all("ctrl_change", 32'h0, 1, 6);
    apply_stimulus(0, 4'b0000, 0, 0, 32'h00, 32'h0);
    apply_stimulus(0, 4'b0100, 0, 0, 32'h14, 32'h0);
    check_all("ctrl_change_rd5", CHK ? 32'h0 : 32'hAA, 1, 6);
    apply_stimulus(0, 4'b0100, 1, 0, 32'h14, 32'h0);
    apply_stimulus(0, 4'b0100, 0, 0, 32'h10, 32'h0);
    check_all("ctrl_change_rd4", 32'h0, 1, 6);
    apply_stimulus(0, 4'b0100, 1, 0, 32'h10, 32'h0);
    apply_stimulus(0, 4'b0000, 0, 0, 32'h00, 32'h0);

    // 300 consecutive Penable-in-IDLE violations saturate the counter.
    for (int i = 0; i < 300; i++) apply_stimulus(0, 4'b0000, 1, 0, 32'h00, 32'h0);
    check_all("saturate", 32'h0, 1, 8'd255);
    apply_stimulus(0, 4'b0000, 0, 0, 32'h00, 32'h0);
    check_all("saturate_hold", 32'h0, 1, 8'd255);

    // Reset during a write access cycle wins over the write.
    apply_stimulus(0, 4'b1000, 0, 1, 32'h10, 32'h77);
    apply_stimulus(1, 4'b1000, 1, 1, 32'h10, 32'h77);
    check_all("rst_mid", 32'h0, 0, 0);
    check_output("rst_mid.state", {30'b0, dut.state}, {30'b0, IDLE});
    apply_stimulus(0, 4'b1000, 0, 0, 32'h10, 32'h0);
    check_all("rst_mid_rd", 32'h0, 0, 0);
    apply_stimulus(0, 4'b1000, 1, 0, 32'h10, 32'h0);
    apply_stimulus(0, 4'b0010, 0, 0, 32'h08, 32'h0);
    check_all("rst_cleared", 32'h0, 0, 0);
    apply_stimulus(0, 4'b0010, 1, 0, 32'h08, 32'h0);
    apply_stimulus(0, 4'b0010, 0, 1, 32'h08, 32'h12345678);
    apply_stimulus(0, 4'b0010, 1, 1, 32'h08, 32'h12345678);
    apply_stimulus(0, 4'b0010, 0, 0, 32'h08, 32'h0);
    check_all("post_rst_rw", 32'h12345678, 0, 0);
    apply_stimulus(0, 4'b0010, 1, 0, 32'h08, 32'h0);
    check_all("post_rst_end", 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
